// File: rtl/cp0_unit_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception
// type codes as delivered by the mem stage, and the ExcCode values they map to.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_TR   = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;
    localparam logic [4:0] EXCCODE_TR  = 5'd13;

    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_BD_BIT   = 31;

    typedef struct packed {
        logic       valid;  // a real exception: save EPC/BD, set EXL
        logic       eret;   // return from exception: clear EXL
        logic [4:0] code;   // ExcCode written to cause[6:2]
    } exc_info_t;

    // Map the mem-stage excepttype word onto the action CP0 must take.
    function automatic exc_info_t decode_exc(input logic [31:0] excepttype);
        exc_info_t info;
        info = '0;
        case (excepttype)
            EXC_INT:  begin info.valid = 1'b1; info.code = EXCCODE_INT; end
            EXC_SYS:  begin info.valid = 1'b1; info.code = EXCCODE_SYS; end
            EXC_RI:   begin info.valid = 1'b1; info.code = EXCCODE_RI;  end
            EXC_OV:   begin info.valid = 1'b1; info.code = EXCCODE_OV;  end
            EXC_TR:   begin info.valid = 1'b1; info.code = EXCCODE_TR;  end
            EXC_ERET: info.eret = 1'b1;
            default:  info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer of CP0. Count free-runs, Compare match raises a sticky
// timer interrupt that is cleared only by a write to Compare.
module cp0_timer
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    // Increment, match detect, then mtc0 writes (a write takes precedence).
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= '0;
            compare_o   <= '0;
            timer_int_o <= 1'b0;
        end else begin
            count_o <= count_o + 32'd1;
            if ((compare_o != 32'd0) && (count_o == compare_o)) begin
                timer_int_o <= 1'b1;
            end
            if (we_i) begin
                if (waddr_i == CP0_REG_COUNT) begin
                    count_o <= data_i;
                end
                if (waddr_i == CP0_REG_COMPARE) begin
                    compare_o   <= data_i;
                    timer_int_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// CP0 register file at the write-back end of the mem->wb CP0 path.
// Holds Status/Cause/EPC/Config, exposes PRId, handles exception entry/eret
// and serves combinational mfc0 reads for the ex stage.
// Build option: define CP0_TIMER_EN to include the Count/Compare timer;
// without it Count/Compare read 0 and timer_int_o is tied low.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VAL     = 32'h004C_0102,
    parameter logic [31:0] CONFIG_RESET = 32'h0000_8000,
    parameter logic [31:0] STATUS_RESET = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] config_q;
    exc_info_t   exc;

    assign exc = decode_exc(excepttype_i);

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );
`else
    assign count_o     = '0;
    assign compare_o   = '0;
    assign timer_int_o = 1'b0;
`endif

    // Status/Cause/EPC update: interrupt sampling, then mtc0, then exception
    // (statement order gives the exception the last word on shared fields).
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RESET;
            cause_q  <= '0;
            epc_q    <= '0;
            config_q <= CONFIG_RESET;
        end else begin
            cause_q[15:10] <= int_i;
            if (we_i) begin
                case (waddr_i)
                    CP0_REG_STATUS: status_q <= data_i;
                    CP0_REG_EPC:    epc_q    <= data_i;
                    CP0_REG_CAUSE: begin
                        cause_q[9:8]   <= data_i[9:8];
                        cause_q[23:22] <= data_i[23:22];
                    end
                    default: ;
                endcase
            end
            if (exc.valid) begin
                // A nested exception keeps the original return point.
                if (!status_q[STATUS_EXL_BIT]) begin
                    epc_q <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                               : current_inst_addr_i;
                    cause_q[CAUSE_BD_BIT] <= is_in_delayslot_i;
                end
                status_q[STATUS_EXL_BIT] <= 1'b1;
                cause_q[6:2]             <= exc.code;
            end else if (exc.eret) begin
                status_q[STATUS_EXL_BIT] <= 1'b0;
            end
        end
    end

    // mfc0 read mux; forwarding of in-flight writes is done in ex, not here.
    always_comb begin
        data_o = '0;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = count_o;
            CP0_REG_COMPARE: data_o = compare_o;
            CP0_REG_STATUS:  data_o = status_q;
            CP0_REG_CAUSE:   data_o = cause_q;
            CP0_REG_EPC:     data_o = epc_q;
            CP0_REG_PRID:    data_o = PRID_VAL;
            CP0_REG_CONFIG:  data_o = config_q;
            default:         data_o = '0;
        endcase
    end

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;
    assign config_o = config_q;
    assign prid_o   = PRID_VAL;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: a driver issues one CP0 transaction per cycle
// and pushes the reference model's expectation; a monitor pops and compares.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] excepttype_i = '0;
    logic [31:0] current_inst_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    cp0_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .data_i              (data_i),
        .raddr_i             (raddr_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] PRID = 32'h004C_0102;

    typedef struct {
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] cfg;
        logic        tint;
    } mstate_t;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rd;
        logic        chk_s;
        mstate_t     s;
    } exp_t;

    exp_t    sb_q[$];
    mstate_t m;
    logic    m_valid = 1'b0;
    int      tests = 0;
    int      fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input mstate_t s, input logic [4:0] a);
        case (a)
            5'd9:    return s.count;
            5'd11:   return s.compare;
            5'd12:   return s.status;
            5'd13:   return s.cause;
            5'd14:   return s.epc;
            5'd15:   return PRID;
            5'd16:   return s.cfg;
            default: return 32'd0;
        endcase
    endfunction

    // One cycle of architectural behaviour: tick, mtc0, exception; later wins.
    function automatic mstate_t model_step(input mstate_t c, input logic r, input logic w,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic [5:0] irq, input logic [31:0] ex,
                                           input logic [31:0] ad, input logic sl);
        mstate_t n;
        int      code;
        if (r) begin
            n.count = 0; n.compare = 0; n.status = 32'h1000_0000; n.cause = 0;
            n.epc = 0; n.cfg = 32'h0000_8000; n.tint = 1'b0;
            return n;
        end
        n = c;
        n.cause[15:10] = irq;
`ifdef CP0_TIMER_EN
        n.count = c.count + 1;
        if (c.compare != 0 && c.count == c.compare) n.tint = 1'b1;
`endif
        if (w) begin
            case (wa)
`ifdef CP0_TIMER_EN
                5'd9:  n.count = wd;
                5'd11: begin n.compare = wd; n.tint = 1'b0; end
`endif
                5'd12: n.status = wd;
                5'd13: n.cause = (n.cause & ~32'h00C0_0300) | (wd & 32'h00C0_0300);
                5'd14: n.epc = wd;
                default: ;
            endcase
        end
        case (ex)
            32'h1:   code = 0;
            32'h8:   code = 8;
            32'hA:   code = 10;
            32'hC:   code = 12;
            32'hD:   code = 13;
            default: code = -1;
        endcase
        if (code >= 0) begin
            if (c.status[1] == 1'b0) begin
                n.epc       = sl ? ad - 4 : ad;
                n.cause[31] = sl;
            end
            n.status[1]  = 1'b1;
            n.cause[6:2] = code[4:0];
        end else if (ex == 32'hE) begin
            n.status[1] = 1'b0;
        end
        return n;
    endfunction

    task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [5:0] irq, input logic [31:0] ex,
                       input logic [31:0] ad, input logic sl);
        exp_t e;
        @(negedge clk);
        rst = r; we_i = w; waddr_i = wa; data_i = wd; raddr_i = ra; int_i = irq;
        excepttype_i = ex; current_inst_addr_i = ad; is_in_delayslot_i = sl;
        e.chk_rd = m_valid;
        e.rd     = model_read(m, ra);
        m        = model_step(m, r, w, wa, wd, irq, ex, ad, sl);
        if (r) m_valid = 1'b1;
        e.chk_s  = m_valid;
        e.s      = m;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [4:0] ra);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ra, 6'd0, 0, 0, 0);
    endtask

    // Monitor: combinational read checked mid-cycle, registers checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk_rd) check("data_o", data_o, e.rd);
                @(posedge clk);
                #1;
                if (e.chk_s) begin
                    check("count", count_o, e.s.count);
                    check("compare", compare_o, e.s.compare);
                    check("status", status_o, e.s.status);
                    check("cause", cause_o, e.s.cause);
                    check("epc", epc_o, e.s.epc);
                    check("config", config_o, e.s.cfg);
                    check("prid", prid_o, PRID);
                    check("timer_int", {31'd0, timer_int_o}, {31'd0, e.s.tint});
                end
            end
        end
    end

    initial begin
        logic [4:0]  ra_set [8];
        logic [31:0] ex_set [10];
        logic [4:0]  wa_set [6];
        logic [4:0]  wa, ra;
        logic [31:0] wd, ex;
        ra_set = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
        ex_set = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'hA, 32'hC, 32'hD, 32'hE, 32'h7};
        wa_set = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd16};

        cyc(1, 0, 0, 0, 5'd12, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 5'd16, 0, 0, 0, 0);
        idle(1, 5'd12);

        cyc(0, 1, 5'd11, 32'd5, 5'd11, 0, 0, 0, 0);
        cyc(0, 1, 5'd9, 32'd0, 5'd9, 0, 0, 0, 0);
        idle(8, 5'd9);
        cyc(0, 1, 5'd11, 32'd20, 5'd11, 0, 0, 0, 0);
        idle(2, 5'd11);

        cyc(0, 0, 0, 0, 5'd14, 0, 32'h8, 32'h100, 0);
        idle(1, 5'd13);
        cyc(0, 0, 0, 0, 5'd12, 0, 32'hE, 0, 0);
        cyc(0, 0, 0, 0, 5'd14, 0, 32'h1, 32'h204, 1);
        cyc(0, 0, 0, 0, 5'd13, 0, 32'hE, 0, 0);
        cyc(0, 0, 0, 0, 5'd12, 0, 32'h8, 32'h100, 0);
        cyc(0, 0, 0, 0, 5'd14, 0, 32'hC, 32'h300, 0);
        cyc(0, 0, 0, 0, 5'd14, 0, 32'hE, 0, 0);

        cyc(0, 1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0, 0, 0, 0);
        idle(1, 5'd13);
        cyc(0, 1, 5'd9, 32'hFFFF_FFFF, 5'd9, 6'd0, 0, 0, 0);
        idle(3, 5'd9);
        cyc(0, 1, 5'd12, 32'h0000_00F0, 5'd12, 6'd0, 32'h8, 32'h400, 1);
        cyc(0, 1, 5'd14, 32'h1234_5678, 5'd14, 6'd5, 32'hD, 32'h500, 0);

        for (int i = 0; i < 1500; i++) begin
            wa = wa_set[$urandom_range(0, 5)];
            wd = $urandom;
            if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = m.count + $urandom_range(1, 6);
            ra = ra_set[$urandom_range(0, 7)];
            ex = ex_set[$urandom_range(0, 9)];
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3, wa, wd, ra,
                6'($urandom), ex, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                1'($urandom_range(0, 1)));
        end
        idle(2, 5'd12);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
